mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu.sv | 188 ++++++++++++++++++
 tb/tb_mdu.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mdu                                                             |
// | Purpose  : Multiply/divide unit with HI/LO result registers. MULT/MULTU/   |
// |            DIV/DIVU run for a fixed number of cycles with Busy high;       |
// |            MTHI/MTLO write HI/LO directly in a single cycle.               |
// | Options  : define MDU_MADD_EN to decode Op 6/7 as MADD/MADDU               |
// |            (multiply-accumulate into {HI,LO}).                             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  Op,
  input  logic        Start,
  input  logic        Cancel,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] c_op_mult  = 3'd0;
  localparam logic [2:0] c_op_multu = 3'd1;
  localparam logic [2:0] c_op_div   = 3'd2;
  localparam logic [2:0] c_op_divu  = 3'd3;
  localparam logic [2:0] c_op_mthi  = 3'd4;
  localparam logic [2:0] c_op_mtlo  = 3'd5;
`ifdef MDU_MADD_EN
  localparam logic [2:0] c_op_madd  = 3'd6;
  localparam logic [2:0] c_op_maddu = 3'd7;
`endif

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;

  logic        w_mul_op;
  logic        w_div_op;
  logic        w_div_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_b_safe;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [63:0] w_result;

  // Classify the incoming Op into multi-cycle multiply-class and divide-class requests
  always_comb begin
    w_mul_op = (Op == c_op_mult) || (Op == c_op_multu);
`ifdef MDU_MADD_EN
    w_mul_op = w_mul_op || (Op == c_op_madd) || (Op == c_op_maddu);
`endif
    w_div_op = (Op == c_op_div) || (Op == c_op_divu);
  end

  // Result datapath working on the operands latched at Start.
  // Signed division is done on magnitudes and the signs are reapplied, so the
  // 0x80000000 / -1 case naturally yields quotient 0x80000000, remainder 0.
  always_comb begin
    w_div_signed = (op_q == c_op_div);
    w_a_neg      = w_div_signed & a_q[31];
    w_b_neg      = w_div_signed & b_q[31];
    w_a_mag      = w_a_neg ? (32'd0 - a_q) : a_q;
    w_b_mag      = w_b_neg ? (32'd0 - b_q) : b_q;
    // Keep the divider well defined for B=0; that result is overridden below.
    w_b_safe     = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
    w_q_mag      = w_a_mag / w_b_safe;
    w_r_mag      = w_a_mag % w_b_safe;
    w_quo        = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    w_rem        = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

    // Sign-extended operands multiplied modulo 2^64 give the signed product
    w_prod_s     = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    w_prod_u     = {32'd0, a_q} * {32'd0, b_q};

    w_result     = {hi_q, lo_q};
    case (op_q)
      c_op_mult:  w_result = w_prod_s;
      c_op_multu: w_result = w_prod_u;
      c_op_div,
      c_op_divu:  w_result = (b_q == 32'd0) ? {a_q, 32'hFFFF_FFFF} : {w_rem, w_quo};
`ifdef MDU_MADD_EN
      c_op_madd:  w_result = {hi_q, lo_q} + w_prod_s;
      c_op_maddu: w_result = {hi_q, lo_q} + w_prod_u;
`endif
      default:    w_result = {hi_q, lo_q};
    endcase
  end

  // Next-state logic: IDLE accepts requests, RUN counts down then commits HI/LO
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          if (w_mul_op || w_div_op) begin
            a_d     = A;
            b_d     = B;
            op_d    = Op;
            cnt_d   = w_div_op ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);
            state_d = ST_RUN;
            busy_d  = 1'b1;
          end else if (Op == c_op_mthi) begin
            hi_d = A;
          end else if (Op == c_op_mtlo) begin
            lo_d = A;
          end
        end
      end
      ST_RUN: begin
        // Cancel wins over a completion on the same edge
        if (Cancel) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cnt_d   = 5'd0;
        end else if (cnt_q == 5'd1) begin
          state_d      = ST_IDLE;
          busy_d       = 1'b0;
          cnt_d        = 5'd0;
          {hi_d, lo_d} = w_result;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= 3'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// Testbench for mdu: vector table, directed corner sequences, randomized ops
// checked against an arithmetic reference model.
module tb_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic [2:0]  Op = 3'd0;
  logic        Start = 1'b0;
  logic        Cancel = 1'b0;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int failures = 0;

  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t vecs[12];

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .Op(Op), .Start(Start),
    .Cancel(Cancel), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Reference: results straight from the arithmetic definitions
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] acc);
    longint          sa, sb;
    longint unsigned ua, ub;
    int              q, r;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: return sa * sb;
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      3'd6: return acc + sa * sb;
      3'd7: return acc + ua * ub;
      default: return acc;
    endcase
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 11))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Launch a multi-cycle op, watch HI/LO hold and count Busy cycles.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int exp_cyc, input int cancel_at,
                        input bit repulse, input bit cancel_on_start);
    int n;
    Op = op; A = a; B = b; Start = 1'b1; Cancel = cancel_on_start;
    tick();
    Start = 1'b0; Cancel = 1'b0;
    n = 0;
    while (Busy === 1'b1 && n < 100) begin
      n++;
      check({name, "_hold_hi"}, 64'(HI), 64'(model_hi));
      check({name, "_hold_lo"}, 64'(LO), 64'(model_lo));
      A = $urandom; B = $urandom;
      if (repulse && n == 2) begin
        Start = 1'b1; Op = 3'd4; A = 32'd5;
      end else begin
        Start = 1'b0; Op = op;
      end
      Cancel = (n == cancel_at);
      tick();
    end
    Start = 1'b0; Cancel = 1'b0; Op = op;
    check({name, "_busy_cycles"}, 64'(n), 64'(exp_cyc));
    check({name, "_hi"}, 64'(HI), 64'(exp_hi));
    check({name, "_lo"}, 64'(LO), 64'(exp_lo));
    model_hi = exp_hi;
    model_lo = exp_lo;
  endtask

  // Single-cycle MTHI/MTLO
  task automatic mt(input string name, input logic [2:0] op, input logic [31:0] a);
    Op = op; A = a; Start = 1'b1;
    tick();
    Start = 1'b0;
    if (op == 3'd4) model_hi = a;
    else model_lo = a;
    check({name, "_busy"}, 64'(Busy), 64'd0);
    check({name, "_hi"}, 64'(HI), 64'(model_hi));
    check({name, "_lo"}, 64'(LO), 64'(model_lo));
    tick();
    check({name, "_busy_after"}, 64'(Busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]  r_op;
    logic [31:0] ra, rb;
    logic [63:0] rexp;

    vecs[0]  = '{3'd0, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, MC};
    vecs[1]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DC};
    vecs[2]  = '{3'd3, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, DC};
    vecs[3]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, DC};
    vecs[4]  = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, DC};
    vecs[5]  = '{3'd3, 32'd100,       32'd7,         32'd2,         32'd14,        DC};
    vecs[6]  = '{3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'd1,         MC};
    vecs[7]  = '{3'd1, 32'hFFFF_FFFF, 32'd2,         32'd1,         32'hFFFF_FFFE, MC};
    vecs[8]  = '{3'd2, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF, DC};
    vecs[9]  = '{3'd3, 32'hFFFF_FFFF, 32'd16,        32'd15,        32'h0FFF_FFFF, DC};
    vecs[10] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         MC};
    vecs[11] = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         DC};

    // Reset state; Start is ignored while reset is asserted
    rst = 1'b0; Op = 3'd5; A = 32'hDEAD_BEEF; Start = 1'b1;
    tick();
    tick();
    check("reset_busy", 64'(Busy), 64'd0);
    check("reset_hi", 64'(HI), 64'd0);
    check("reset_lo", 64'(LO), 64'd0);
    Start = 1'b0;
    rst = 1'b1;
    tick();
    check("post_reset_lo", 64'(LO), 64'd0);

    // Vector table
    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].cyc, 0, 1'b0, 1'b0);
    end

    // MULTU with an MTHI re-pulse during RUN (ignored)
    run_op("multu_repulse", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 32'd1, MC, 0, 1'b1, 1'b0);
    tick();
    check("repulse_no_late_busy", 64'(Busy), 64'd0);

    // MTLO then MTHI
    mt("mtlo", 3'd5, 32'h1234_5678);
    mt("mthi", 3'd4, 32'd9);

    // DIV cancelled on cycle 3: HI/LO keep prior values
    run_op("div_cancel", 3'd2, 32'd100, 32'd3, model_hi, model_lo, 3, 3, 1'b0, 1'b0);
    tick();
    check("cancel_idle_busy", 64'(Busy), 64'd0);

    // Cancel with Start in IDLE: Start accepted
    run_op("cancel_start", 3'd0, 32'd3, 32'd4, 32'd0, 32'd12, MC, 0, 1'b0, 1'b1);

    // DIV with reset asserted in cycle 4 of RUN
    Op = 3'd2; A = 32'd50; B = 32'd7; Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (3) tick();
    check("rst_mid_busy_before", 64'(Busy), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_busy", 64'(Busy), 64'd0);
    check("rst_mid_hi", 64'(HI), 64'd0);
    check("rst_mid_lo", 64'(LO), 64'd0);
    tick();
    // First posedge with rst released accepts the request
    Op = 3'd5; A = 32'h0000_0055; Start = 1'b1; rst = 1'b1;
    tick();
    Start = 1'b0;
    model_hi = 32'd0;
    model_lo = 32'h0000_0055;
    check("first_accept_lo", 64'(LO), 64'h55);
    check("first_accept_busy", 64'(Busy), 64'd0);
    tick();
    check("after_rst_idle", 64'(Busy), 64'd0);

    // Op 7 from HI=0, LO=FFFFFFFF with A=B=1
    mt("pre_madd_hi", 3'd4, 32'd0);
    mt("pre_madd_lo", 3'd5, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
    run_op("maddu", 3'd7, 32'd1, 32'd1, 32'd1, 32'd0, MC, 0, 1'b0, 1'b0);
`else
    Op = 3'd7; A = 32'd1; B = 32'd1; Start = 1'b1;
    tick();
    Start = 1'b0;
    check("op7_noop_busy", 64'(Busy), 64'd0);
    check("op7_noop_hi", 64'(HI), 64'(model_hi));
    check("op7_noop_lo", 64'(LO), 64'(model_lo));
    tick();
    check("op7_noop_busy2", 64'(Busy), 64'd0);
`endif

    // Randomized operations against the reference model
    for (int i = 0; i < 60; i++) begin
      r_op = 3'($urandom_range(0, 7));
      ra = rnd_operand();
      rb = rnd_operand();
      case (r_op)
        3'd4, 3'd5: mt($sformatf("rnd%0d_mt", i), r_op, ra);
        3'd6, 3'd7: begin
`ifdef MDU_MADD_EN
          rexp = ref_result(r_op, ra, rb, {model_hi, model_lo});
          run_op($sformatf("rnd%0d_madd", i), r_op, ra, rb, rexp[63:32], rexp[31:0],
                 MC, 0, 1'b0, 1'b0);
`else
          Op = r_op; A = ra; B = rb; Start = 1'b1;
          tick();
          Start = 1'b0;
          check($sformatf("rnd%0d_noop_busy", i), 64'(Busy), 64'd0);
          check($sformatf("rnd%0d_noop_hilo", i), {HI, LO}, {model_hi, model_lo});
`endif
        end
        default: begin
          rexp = ref_result(r_op, ra, rb, {model_hi, model_lo});
          run_op($sformatf("rnd%0d_op%0d", i, r_op), r_op, ra, rb, rexp[63:32], rexp[31:0],
                 (r_op >= 3'd2) ? DC : MC, 0, 1'b0, 1'b0);
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
